// File: rtl/axil2cpu_bridge.sv
// AXI4-Lite slave that serialises reads and writes onto a single-strobe CPU register bus.
// One transaction is outstanding at a time; simultaneous read/write requests alternate.
module axil2cpu_bridge #(
  parameter int CPU_ADDR_WIDTH = 12,
  parameter int CPU_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int RD_LAT         = 2
) (
  input  logic                      clks,
  input  logic                      reset,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  input  logic [CPU_DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [3:0]                s_axil_wstrb,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  output logic [1:0]                s_axil_bresp,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic [CPU_DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      cpu_wr,
  output logic [CPU_ADDR_WIDTH-1:0] cpu_wr_addr,
  output logic [CPU_DATA_WIDTH-1:0] cpu_data_in,
  output logic                      cpu_rd,
  input  logic [CPU_DATA_WIDTH-1:0] cpu_data_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_EXEC = 3'd1,
    WR_RESP = 3'd2,
    RD_WAIT = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] LAT_LAST    = 4'(RD_LAT - 1);

  state_t                      state_r;
  logic                        last_grant_r;
  logic [3:0]                  rd_cnt_r;
  logic [3:0]                  wstrb_r;
  logic                        cpu_wr_r;
  logic                        cpu_rd_r;
  logic [CPU_ADDR_WIDTH-1:0]   addr_r;
  logic [CPU_DATA_WIDTH-1:0]   din_r;
  logic                        bvalid_r;
  logic [1:0]                  bresp_r;
  logic                        rvalid_r;
  logic [1:0]                  rresp_r;
  logic [CPU_DATA_WIDTH-1:0]   rdata_r;

  logic                        wr_pend_s;
  logic                        rd_pend_s;
  logic                        grant_wr_s;
  logic                        grant_rd_s;
  logic                        unused_addr_bits_s;

  // Byte-lane and alias bits of the AXI addresses are deliberately ignored.
  assign unused_addr_bits_s = ^{s_axil_awaddr, s_axil_araddr};

  // IDLE arbitration: a write needs AW and W together; ties go opposite to last_grant_r.
  always_comb begin
    wr_pend_s  = s_axil_awvalid & s_axil_wvalid;
    rd_pend_s  = s_axil_arvalid;
    grant_wr_s = 1'b0;
    grant_rd_s = 1'b0;
    if ((state_r == IDLE) && !reset) begin
      grant_wr_s = wr_pend_s & (~rd_pend_s | ~last_grant_r);
      grant_rd_s = rd_pend_s & ~grant_wr_s;
    end else begin
      grant_wr_s = 1'b0;
      grant_rd_s = 1'b0;
    end
  end

  // Transaction sequencer with registered bus strobes and AXI responses.
  always_ff @(posedge clks) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b0;
      rd_cnt_r     <= 4'd0;
      wstrb_r      <= 4'd0;
      cpu_wr_r     <= 1'b0;
      cpu_rd_r     <= 1'b0;
      addr_r       <= '0;
      din_r        <= '0;
      bvalid_r     <= 1'b0;
      bresp_r      <= RESP_OKAY;
      rvalid_r     <= 1'b0;
      rresp_r      <= RESP_OKAY;
      rdata_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_wr_s) begin
            addr_r       <= s_axil_awaddr[CPU_ADDR_WIDTH+1:2];
            din_r        <= s_axil_wdata;
            wstrb_r      <= s_axil_wstrb;
            cpu_wr_r     <= (s_axil_wstrb == 4'hF);
            last_grant_r <= 1'b1;
            state_r      <= WR_EXEC;
          end else if (grant_rd_s) begin
            addr_r       <= s_axil_araddr[CPU_ADDR_WIDTH+1:2];
            rd_cnt_r     <= 4'd0;
            cpu_rd_r     <= 1'b1;
            last_grant_r <= 1'b0;
            state_r      <= RD_WAIT;
          end
        end
        WR_EXEC: begin
          cpu_wr_r <= 1'b0;
          bresp_r  <= (wstrb_r == 4'hF) ? RESP_OKAY : RESP_SLVERR;
          bvalid_r <= 1'b1;
          state_r  <= WR_RESP;
        end
        WR_RESP: begin
          if (s_axil_bready) begin
            bvalid_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        RD_WAIT: begin
          cpu_rd_r <= 1'b0;
          // Sample edge is RD_LAT cycles after cpu_rd was first driven.
          if (rd_cnt_r == LAT_LAST) begin
            rdata_r  <= cpu_data_out;
            rresp_r  <= RESP_OKAY;
            rvalid_r <= 1'b1;
            state_r  <= RD_RESP;
          end else begin
            rd_cnt_r <= rd_cnt_r + 4'd1;
          end
        end
        RD_RESP: begin
          if (s_axil_rready) begin
            rvalid_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          cpu_wr_r <= 1'b0;
          cpu_rd_r <= 1'b0;
          bvalid_r <= 1'b0;
          rvalid_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign s_axil_awready = grant_wr_s;
  assign s_axil_wready  = grant_wr_s;
  assign s_axil_arready = grant_rd_s;
  assign s_axil_bvalid  = bvalid_r;
  assign s_axil_bresp   = bresp_r;
  assign s_axil_rvalid  = rvalid_r;
  assign s_axil_rdata   = rdata_r;
  assign s_axil_rresp   = rresp_r;
  assign cpu_wr         = cpu_wr_r;
  assign cpu_rd         = cpu_rd_r;
  assign cpu_wr_addr    = addr_r;
  assign cpu_data_in    = din_r;

endmodule

// File: tb/tb_axil2cpu_bridge.sv
// Bench for axil2cpu_bridge: transaction-level timing model checked every cycle,
// directed scenarios with literal expectations, then randomized mixed traffic.
module tb_axil2cpu_bridge;
  localparam int CAW    = 12;
  localparam int AAW    = 16;
  localparam int RD_LAT = 2;
  localparam int BUDGET = 400;

  logic        clks = 1'b0;
  logic        reset;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [15:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        cpu_wr, cpu_rd;
  logic [11:0] cpu_wr_addr;
  logic [31:0] cpu_data_in, cpu_data_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  axil2cpu_bridge #(.CPU_ADDR_WIDTH(CAW), .CPU_DATA_WIDTH(32), .AXI_ADDR_WIDTH(AAW), .RD_LAT(RD_LAT)) dut (
    .clks(clks), .reset(reset),
    .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
    .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .cpu_wr(cpu_wr), .cpu_wr_addr(cpu_wr_addr), .cpu_data_in(cpu_data_in),
    .cpu_rd(cpu_rd), .cpu_data_out(cpu_data_out)
  );

  always #5 clks = ~clks;

  always @(posedge clks) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hA5A5_0001;
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles (cycle %0d)", name, BUDGET, cyc);
  endtask

  // Register block behind the bridge: registered read data, noise when not reading.
  logic [31:0] env_mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) env_mem[i] = init_word(i);
    forever begin
      @(posedge clks);
      if (cpu_wr) env_mem[cpu_wr_addr] = cpu_data_in;
      cpu_data_out <= cpu_rd ? env_mem[cpu_wr_addr] : $urandom;
    end
  end

  // Transaction-level model state (owned by the compare process) and monitor records.
  logic [31:0] exp_mem [4096];
  bit          mb, mk, mfull, mlastw;
  int          mage;
  logic [11:0] maddr;
  logic [31:0] mdin, mrdata;
  bit          e_gw, e_gr, e_cw, e_cr, e_bv, e_rv, prev_bv, prev_rv;
  int          hs_w_cyc, hs_r_cyc, hs_b_cyc, b_first_cyc, r_first_cyc, n_wr, n_rd;
  logic [11:0] mon_wr_addr, mon_rd_addr;
  logic [31:0] mon_wr_data, mon_rdata;
  logic [1:0]  mon_bresp, mon_rresp;
  bit          glog[$];

  initial begin
    for (int i = 0; i < 4096; i++) exp_mem[i] = init_word(i);
    mb = 0; mk = 0; mfull = 0; mlastw = 0; mage = 0; maddr = 0; mdin = 0; mrdata = 0;
    prev_bv = 0; prev_rv = 0; n_wr = 0; n_rd = 0;
    forever begin
      @(negedge clks);
      if (reset) begin
        mb = 0; mage = 0; mlastw = 0; maddr = 0; mdin = 0; mrdata = 0;
        prev_bv = 0; prev_rv = 0;
        continue;
      end
      e_gw = !mb && awvalid && wvalid && (!arvalid || !mlastw);
      e_gr = !mb && arvalid && !e_gw;
      e_cw = mb && !mk && (mage == 1) && mfull;
      e_cr = mb && mk && (mage == 1);
      e_bv = mb && !mk && (mage >= 2);
      e_rv = mb && mk && (mage >= RD_LAT + 1);
      chk("awready", 32'(awready), 32'(e_gw));
      chk("wready", 32'(wready), 32'(e_gw));
      chk("arready", 32'(arready), 32'(e_gr));
      chk("cpu_wr", 32'(cpu_wr), 32'(e_cw));
      chk("cpu_rd", 32'(cpu_rd), 32'(e_cr));
      chk("bvalid", 32'(bvalid), 32'(e_bv));
      chk("rvalid", 32'(rvalid), 32'(e_rv));
      chk("cpu_wr_addr", 32'(cpu_wr_addr), 32'(maddr));
      chk("cpu_data_in", cpu_data_in, mdin);
      if (e_bv) chk("bresp", 32'(bresp), mfull ? 32'd0 : 32'd2);
      if (e_rv) begin
        chk("rdata", rdata, mrdata);
        chk("rresp", 32'(rresp), 32'd0);
      end
      if (awready && awvalid && wvalid) begin hs_w_cyc = cyc; glog.push_back(1'b1); end
      if (arready && arvalid) begin hs_r_cyc = cyc; glog.push_back(1'b0); end
      if (cpu_wr) begin n_wr++; mon_wr_addr = cpu_wr_addr; mon_wr_data = cpu_data_in; end
      if (cpu_rd) begin n_rd++; mon_rd_addr = cpu_wr_addr; end
      if (bvalid && !prev_bv) b_first_cyc = cyc;
      if (rvalid && !prev_rv) r_first_cyc = cyc;
      if (bvalid && bready) begin hs_b_cyc = cyc; mon_bresp = bresp; end
      if (rvalid && rready) begin mon_rdata = rdata; mon_rresp = rresp; end
      prev_bv = bvalid;
      prev_rv = rvalid;
      if (e_gw) begin
        mb = 1; mk = 0; mage = 1; maddr = awaddr[13:2]; mdin = wdata;
        mfull = (wstrb == 4'hF); mlastw = 1;
        if (mfull) exp_mem[maddr] = wdata;
      end else if (e_gr) begin
        mb = 1; mk = 1; mage = 1; maddr = araddr[13:2]; mrdata = exp_mem[maddr]; mlastw = 0;
      end else if ((e_bv && bready) || (e_rv && rready)) begin
        mb = 0;
      end else if (mb) begin
        mage++;
      end
    end
  end

  // Response-channel ready generators.
  bit hold_b = 0;
  bit rand_ready = 0;
  initial begin
    bready = 1'b0;
    rready = 1'b0;
    forever begin
      @(posedge clks); #1;
      bready = hold_b ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          lag;
    bit          w_first;
  } wjob_t;
  wjob_t       wq[$];
  logic [15:0] rq[$];
  int          w_done = 0;
  int          r_done = 0;

  // Write-channel master: AW and W may be raised a few cycles apart.
  initial begin : wr_master
    wjob_t j;
    int    n;
    bit    ab;
    awvalid = 0; wvalid = 0; awaddr = 0; wdata = 0; wstrb = 0;
    forever begin
      @(posedge clks); #1;
      if (wq.size() != 0 && !reset) begin
        j = wq.pop_front();
        awaddr = j.a; wdata = j.d; wstrb = j.s;
        if (j.w_first) wvalid = 1'b1; else awvalid = 1'b1;
        if (j.lag > 0) begin repeat (j.lag) @(posedge clks); #1; end
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0; ab = 0;
        forever begin
          @(negedge clks);
          if (reset) begin ab = 1; break; end
          if (awready && wready) break;
          n++;
          if (n > BUDGET) begin timeout_fail("aw_w_handshake"); ab = 1; break; end
        end
        @(posedge clks); #1;
        awvalid = 0; wvalid = 0; awaddr = 16'($urandom); wdata = $urandom;
        if (!ab) begin
          n = 0;
          forever begin
            @(negedge clks);
            if (reset) break;
            if (bvalid && bready) break;
            n++;
            if (n > BUDGET) begin timeout_fail("b_handshake"); break; end
          end
        end
        w_done++;
      end
    end
  end

  // Read-channel master.
  initial begin : rd_master
    logic [15:0] a;
    int          n;
    bit          ab;
    arvalid = 0; araddr = 0;
    forever begin
      @(posedge clks); #1;
      if (rq.size() != 0 && !reset) begin
        a = rq.pop_front();
        araddr = a; arvalid = 1'b1;
        n = 0; ab = 0;
        forever begin
          @(negedge clks);
          if (reset) begin ab = 1; break; end
          if (arready) break;
          n++;
          if (n > BUDGET) begin timeout_fail("ar_handshake"); ab = 1; break; end
        end
        @(posedge clks); #1;
        arvalid = 0; araddr = 16'($urandom);
        if (!ab) begin
          n = 0;
          forever begin
            @(negedge clks);
            if (reset) break;
            if (rvalid && rready) break;
            n++;
            if (n > BUDGET) begin timeout_fail("r_handshake"); break; end
          end
        end
        r_done++;
      end
    end
  end

  task automatic push_w(logic [15:0] a, logic [31:0] d, logic [3:0] s);
    wjob_t j;
    j.a = a; j.d = d; j.s = s; j.lag = 0; j.w_first = 0;
    wq.push_back(j);
  endtask

  task automatic wait_done(int wn, int rn);
    int n = 0;
    while ((w_done < wn || r_done < rn) && n < 20 * BUDGET) begin
      @(posedge clks);
      n++;
    end
    chk("transactions_done_in_budget", 32'(w_done >= wn && r_done >= rn), 32'd1);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base_wr, base_rd, g, n;
    wjob_t j;
    logic [15:0] a;
    reset = 1'b1;
    repeat (3) @(posedge clks);
    #1 reset = 1'b0;
    @(negedge clks);
    chk("reset_bvalid", 32'(bvalid), 32'd0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_cpu_wr_addr", 32'(cpu_wr_addr), 32'd0);
    chk("reset_cpu_data_in", cpu_data_in, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_bresp", 32'(bresp), 32'd0);
    chk("reset_rresp", 32'(rresp), 32'd0);

    // Full-strobe write.
    push_w(16'h0008, 32'h1234_5678, 4'hF);
    wait_done(1, 0);
    chk("wr1_cpu_wr_addr", 32'(mon_wr_addr), 32'h002);
    chk("wr1_cpu_data_in", mon_wr_data, 32'h1234_5678);
    chk("wr1_b_latency", 32'(b_first_cyc - hs_w_cyc), 32'd2);
    chk("wr1_bresp", 32'(mon_bresp), 32'd0);
    chk("wr1_pulses", 32'(n_wr), 32'd1);

    // Read with the register block returning data one cycle after cpu_rd.
    rq.push_back(16'h0010);
    wait_done(1, 1);
    chk("rd1_addr", 32'(mon_rd_addr), 32'h004);
    chk("rd1_rdata", mon_rdata, 32'hA5A5_0001);
    chk("rd1_r_latency", 32'(r_first_cyc - hs_r_cyc), 32'd3);
    chk("rd1_rresp", 32'(mon_rresp), 32'd0);
    chk("rd1_pulses", 32'(n_rd), 32'd1);

    // Partial strobe: write dropped, SLVERR.
    push_w(16'h0018, 32'hDEAD_BEEF, 4'h3);
    wait_done(2, 1);
    chk("wr_partial_no_pulse", 32'(n_wr), 32'd1);
    chk("wr_partial_bresp", 32'(mon_bresp), 32'd2);

    // Simultaneous requests after a write: read, then write, then the next read.
    g = glog.size();
    push_w(16'h000C, 32'h0BAD_F00D, 4'hF);
    rq.push_back(16'h0004);
    rq.push_back(16'h0008);
    wait_done(3, 3);
    chk("arb_grant_count", 32'(glog.size() - g), 32'd3);
    if (glog.size() >= g + 3) begin
      chk("arb_first_is_read", 32'(glog[g]), 32'd0);
      chk("arb_second_is_write", 32'(glog[g+1]), 32'd1);
      chk("arb_third_is_read", 32'(glog[g+2]), 32'd0);
    end

    // Stalled B response while a read waits.
    hold_b = 1;
    push_w(16'h0020, 32'h5555_AAAA, 4'hF);
    n = 0;
    while (!bvalid && n < BUDGET) begin @(negedge clks); n++; end
    chk("stall_bvalid_seen", 32'(bvalid), 32'd1);
    rq.push_back(16'h0010);
    repeat (6) @(posedge clks);
    hold_b = 0;
    wait_done(4, 4);
    chk("stall_read_after_b", 32'(hs_r_cyc - hs_b_cyc), 32'd1);

    // Reset during the second RD_WAIT cycle.
    base_rd = n_rd;
    rq.push_back(16'h0004);
    n = 0;
    while (!(arvalid && arready) && n < BUDGET) begin @(negedge clks); n++; end
    chk("rst_ar_handshake_seen", 32'(arvalid && arready), 32'd1);
    @(posedge clks);
    @(posedge clks);
    #1 reset = 1'b1;
    @(posedge clks);
    #1 reset = 1'b0;
    @(negedge clks);
    chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
    chk("rst_mid_bvalid", 32'(bvalid), 32'd0);
    chk("rst_mid_cpu_rd", 32'(cpu_rd), 32'd0);
    chk("rst_mid_cpu_wr", 32'(cpu_wr), 32'd0);
    chk("rst_mid_addr", 32'(cpu_wr_addr), 32'd0);
    chk("rst_mid_one_rd_pulse", 32'(n_rd - base_rd), 32'd1);
    wait_done(4, 5);
    rq.push_back(16'h0000);
    wait_done(4, 6);
    chk("post_reset_rdata", mon_rdata, 32'hC0DE_0000);
    chk("post_reset_rresp", 32'(mon_rresp), 32'd0);

    // Randomized mixed traffic with aliased addresses and random back-pressure.
    rand_ready = 1;
    base_wr = w_done;
    base_rd = r_done;
    for (int i = 0; i < 150; i++) begin
      a = 16'($urandom);
      a[13:2] = 12'($urandom_range(0, 15));
      j.a = a;
      j.d = $urandom;
      j.s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      j.lag = $urandom_range(0, 2);
      j.w_first = 1'($urandom_range(0, 1));
      wq.push_back(j);
      a = 16'($urandom);
      a[13:2] = 12'($urandom_range(0, 15));
      rq.push_back(a);
    end
    wait_done(base_wr + 150, base_rd + 150);
    repeat (4) @(posedge clks);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
